// File: rtl/mips_pkg.sv
// Shared MIPS pipeline encodings: ALU opcodes, multiply/divide ops, forwarding selects
// and the multiply/divide FSM state type.
package mips_pkg;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_NOR  = 4'd4;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SLTU = 4'd8;
    localparam logic [3:0] ALU_SLL  = 4'd9;
    localparam logic [3:0] ALU_SRL  = 4'd10;
    localparam logic [3:0] ALU_SRA  = 4'd11;

    localparam logic [2:0] MDU_NONE  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIVU  = 3'd2;
    localparam logic [2:0] MDU_MFHI  = 3'd3;
    localparam logic [2:0] MDU_MFLO  = 3'd4;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_WB  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    typedef enum logic {
        MDU_IDLE,
        MDU_RUN
    } mdu_state_t;

    function automatic logic is_mdu_arith(input logic [2:0] op);
        return (op == MDU_MULTU) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// HI/LO are updated only on the final iteration, so an aborted operation leaves no trace.
module mdu_iter
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MDU_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(MDU_CYCLES);

    mdu_state_t          state, state_nx;
    logic [CNT_W-1:0]    cnt;
    logic [2*DATA_W-1:0] acc, acc_nx;
    logic [DATA_W-1:0]   opb;
    logic                is_div;
    logic                last;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W+1:0]   div_diff;

    assign busy = (state == MDU_RUN);
    assign last = busy && (cnt == '0);

    always_comb begin
        state_nx = state;
        case (state)
            MDU_IDLE: if (start) state_nx = MDU_RUN;
            MDU_RUN:  if (last)  state_nx = MDU_IDLE;
            default:  state_nx = MDU_IDLE;
        endcase
    end

    // Multiply: add opb into the upper half when the LSB is set, then shift right with carry.
    // Divide: the shifted partial remainder needs DATA_W+1 bits, since it can exceed 2^DATA_W-1.
    always_comb begin
        mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opb} : '0);
        div_diff = {1'b0, acc[2*DATA_W-1:DATA_W-1]} - {2'b00, opb};
        acc_nx   = {mul_sum, acc[DATA_W-1:1]};
        if (is_div) begin
            if (!div_diff[DATA_W+1])
                acc_nx = {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
            else
                acc_nx = {acc[2*DATA_W-2:0], 1'b0};
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= MDU_IDLE;
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            is_div <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state <= state_nx;
            if (state == MDU_IDLE && start) begin
                acc    <= {{DATA_W{1'b0}}, a};
                opb    <= b;
                is_div <= (op == MDU_DIVU);
                cnt    <= CNT_W'(MDU_CYCLES - 1);
            end else if (busy) begin
                acc <= acc_nx;
                cnt <= cnt - 1'b1;
                if (last) begin
                    hi <= acc_nx[2*DATA_W-1:DATA_W];
                    lo <= acc_nx[DATA_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/execute_stage.sv
// MIPS EX stage: forwarding muxes, ALU, iterative MDU and the EX/MEM pipeline register.
// A multi-cycle MDU op stalls any later MDU instruction and inserts bubbles into MEM.
module execute_stage
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int MDU_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrtE,
    input  logic              MemWrtE,
    input  logic              ResultSrcE,
    input  logic              ALUSrcE,
    input  logic [3:0]        ALUCtrlE,
    input  logic [2:0]        MduOpE,
    input  logic [DATA_W-1:0] RD1E,
    input  logic [DATA_W-1:0] RD2E,
    input  logic [DATA_W-1:0] ImmExtE,
    input  logic [DATA_W-1:0] PCplus4E,
    input  logic [REG_AW-1:0] RD_E,
    input  logic [1:0]        ForwardAE,
    input  logic [1:0]        ForwardBE,
    input  logic [DATA_W-1:0] ResultW,
    output logic              ZeroE,
    output logic              MduStallE,
    output logic              RegWrtMem,
    output logic              MemWrtMem,
    output logic              ResultSrcMem,
    output logic [REG_AW-1:0] RD_Mem,
    output logic [DATA_W-1:0] PCplus4Mem,
    output logic [DATA_W-1:0] WriteDataMem,
    output logic [DATA_W-1:0] ALU_ResultMem
);

    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0] src_a, fwd_b, src_b, alu_y, ex_result;
    logic [DATA_W-1:0] mdu_hi, mdu_lo;
    logic [SH_W-1:0]   shamt;
    logic              mdu_busy, mdu_arith, mdu_start;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        src_a = RD1E;
        case (ForwardAE)
            FWD_WB:  src_a = ResultW;
            FWD_MEM: src_a = ALU_ResultMem;
            default: src_a = RD1E;
        endcase
        fwd_b = RD2E;
        case (ForwardBE)
            FWD_WB:  fwd_b = ResultW;
            FWD_MEM: fwd_b = ALU_ResultMem;
            default: fwd_b = RD2E;
        endcase
        src_b = ALUSrcE ? ImmExtE : fwd_b;
    end

    assign shamt = src_a[SH_W-1:0];

    always_comb begin
        alu_y = '0;
        case (ALUCtrlE)
            ALU_AND:  alu_y = src_a & src_b;
            ALU_OR:   alu_y = src_a | src_b;
            ALU_ADD:  alu_y = src_a + src_b;
            ALU_XOR:  alu_y = src_a ^ src_b;
            ALU_NOR:  alu_y = ~(src_a | src_b);
            ALU_SUB:  alu_y = src_a - src_b;
            ALU_SLT:  alu_y = {{(DATA_W-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLTU: alu_y = {{(DATA_W-1){1'b0}}, src_a < src_b};
            ALU_SLL:  alu_y = src_b << shamt;
            ALU_SRL:  alu_y = src_b >> shamt;
            ALU_SRA:  alu_y = $signed(src_b) >>> shamt;
            default:  alu_y = '0;
        endcase
    end

    assign ZeroE = (alu_y == '0);

    always_comb begin
        ex_result = alu_y;
        case (MduOpE)
            MDU_MFHI: ex_result = mdu_hi;
            MDU_MFLO: ex_result = mdu_lo;
            default:  ex_result = alu_y;
        endcase
    end

    assign mdu_arith = is_mdu_arith(MduOpE);
    assign mdu_start = mdu_arith && !mdu_busy;
    assign MduStallE = mdu_busy && (MduOpE != MDU_NONE);

    mdu_iter #(
        .DATA_W     (DATA_W),
        .MDU_CYCLES (MDU_CYCLES)
    ) u_mdu (
        .clk   (clk),
        .rst   (rst),
        .start (mdu_start),
        .op    (MduOpE),
        .a     (src_a),
        .b     (fwd_b),
        .busy  (mdu_busy),
        .hi    (mdu_hi),
        .lo    (mdu_lo)
    );

    // A stalled cycle forwards a zeroed bubble; MULTU/DIVU themselves never write the register file.
    always_ff @(posedge clk) begin
        if (rst || MduStallE) begin
            RegWrtMem     <= 1'b0;
            MemWrtMem     <= 1'b0;
            ResultSrcMem  <= 1'b0;
            RD_Mem        <= '0;
            PCplus4Mem    <= '0;
            WriteDataMem  <= '0;
            ALU_ResultMem <= '0;
        end else begin
            RegWrtMem     <= RegWrtE && !mdu_arith;
            MemWrtMem     <= MemWrtE;
            ResultSrcMem  <= ResultSrcE;
            RD_Mem        <= RD_E;
            PCplus4Mem    <= PCplus4E;
            WriteDataMem  <= fwd_b;
            ALU_ResultMem <= ex_result;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage: ALU, forwarding, MDU stall/bubbles, reset abort.
module tb_execute_stage;
    import mips_pkg::*;

    logic        clk, rst;
    logic        RegWrtE, MemWrtE, ResultSrcE, ALUSrcE;
    logic [3:0]  ALUCtrlE;
    logic [2:0]  MduOpE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCplus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        ZeroE, MduStallE, RegWrtMem, MemWrtMem, ResultSrcMem;
    logic [4:0]  RD_Mem;
    logic [31:0] PCplus4Mem, WriteDataMem, ALU_ResultMem;

    int n_checks = 0;
    int n_errors = 0;

    execute_stage dut (
        .clk           (clk),
        .rst           (rst),
        .RegWrtE       (RegWrtE),
        .MemWrtE       (MemWrtE),
        .ResultSrcE    (ResultSrcE),
        .ALUSrcE       (ALUSrcE),
        .ALUCtrlE      (ALUCtrlE),
        .MduOpE        (MduOpE),
        .RD1E          (RD1E),
        .RD2E          (RD2E),
        .ImmExtE       (ImmExtE),
        .PCplus4E      (PCplus4E),
        .RD_E          (RD_E),
        .ForwardAE     (ForwardAE),
        .ForwardBE     (ForwardBE),
        .ResultW       (ResultW),
        .ZeroE         (ZeroE),
        .MduStallE     (MduStallE),
        .RegWrtMem     (RegWrtMem),
        .MemWrtMem     (MemWrtMem),
        .ResultSrcMem  (ResultSrcMem),
        .RD_Mem        (RD_Mem),
        .PCplus4Mem    (PCplus4Mem),
        .WriteDataMem  (WriteDataMem),
        .ALU_ResultMem (ALU_ResultMem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic alu_op(input string tag, input logic [3:0] ctrl,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        ALUCtrlE = ctrl;
        RD1E     = a;
        RD2E     = b;
        settle();
        check({tag, "_zero"}, {31'b0, ZeroE}, {31'b0, exp == 32'h0});
        tick();
        check(tag, ALU_ResultMem, exp);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40 && MduStallE; i++) tick();
        check({tag, "_timeout"}, {31'b0, MduStallE}, 32'h0);
    endtask

    task automatic run_mdu(input string tag, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        MduOpE = op;
        RD1E   = a;
        RD2E   = b;
        tick();
        MduOpE = MDU_MFLO;
        settle();
        wait_idle(tag);
        tick();
        check({tag, "_lo"}, ALU_ResultMem, exp_lo);
        MduOpE = MDU_MFHI;
        tick();
        check({tag, "_hi"}, ALU_ResultMem, exp_hi);
        MduOpE = MDU_NONE;
    endtask

    function automatic logic [31:0] mem_or();
        return {23'b0, RegWrtMem, MemWrtMem, ResultSrcMem, 4'b0} | {27'b0, RD_Mem}
               | PCplus4Mem | WriteDataMem | ALU_ResultMem;
    endfunction

    initial begin
        int stall_cnt;

        rst = 1'b1;
        RegWrtE = 1'b0; MemWrtE = 1'b0; ResultSrcE = 1'b0; ALUSrcE = 1'b0;
        ALUCtrlE = ALU_ADD; MduOpE = MDU_NONE;
        RD1E = '0; RD2E = '0; ImmExtE = '0; PCplus4E = '0; ResultW = '0;
        RD_E = '0; ForwardAE = FWD_REG; ForwardBE = FWD_REG;
        tick();
        tick();
        check("reset_mem", mem_or(), 32'h0);
        check("reset_stall", {31'b0, MduStallE}, 32'h0);
        rst = 1'b0;

        // Plain ADD
        RD1E = 32'd5; RD2E = 32'd7; ALUCtrlE = ALU_ADD; RegWrtE = 1'b1; RD_E = 5'd3;
        PCplus4E = 32'h400;
        settle();
        check("add_zero", {31'b0, ZeroE}, 32'h0);
        tick();
        check("add_res", ALU_ResultMem, 32'd12);
        check("add_regwrt", {31'b0, RegWrtMem}, 32'h1);
        check("add_rd", {27'b0, RD_Mem}, 32'd3);
        check("add_pc4", PCplus4Mem, 32'h400);

        // Forward from MEM, then from WB
        ForwardAE = FWD_MEM; RD2E = 32'd3; ALUCtrlE = ALU_SUB;
        tick();
        check("fwd_mem_sub", ALU_ResultMem, 32'd9);
        ForwardAE = FWD_WB; ResultW = 32'h8000_0000; RD2E = 32'd0; ALUCtrlE = ALU_SLT;
        tick();
        check("fwd_wb_slt", ALU_ResultMem, 32'd1);
        ALUCtrlE = ALU_SLTU;
        settle();
        check("sltu_zero", {31'b0, ZeroE}, 32'h1);
        tick();
        check("fwd_wb_sltu", ALU_ResultMem, 32'd0);

        // Store: immediate operand B, store data forwarded from WB
        ForwardAE = FWD_REG; ALUSrcE = 1'b1; ImmExtE = 32'd8; RD1E = 32'h100;
        ForwardBE = FWD_WB; ResultW = 32'hDEAD_BEEF; MemWrtE = 1'b1; RegWrtE = 1'b0;
        ALUCtrlE = ALU_ADD;
        tick();
        check("sw_addr", ALU_ResultMem, 32'h108);
        check("sw_data", WriteDataMem, 32'hDEAD_BEEF);
        check("sw_memwrt", {31'b0, MemWrtMem}, 32'h1);
        check("sw_regwrt", {31'b0, RegWrtMem}, 32'h0);
        ALUSrcE = 1'b0; ForwardBE = FWD_REG; MemWrtE = 1'b0; RegWrtE = 1'b1;

        alu_op("sra", ALU_SRA,  32'd4, 32'hF000_000F, 32'hFF00_0000);
        alu_op("srl", ALU_SRL,  32'd4, 32'hF000_000F, 32'h0F00_0000);
        alu_op("sll", ALU_SLL,  32'd4, 32'hF000_000F, 32'h0000_00F0);
        alu_op("xor", ALU_XOR,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0);
        alu_op("nor", ALU_NOR,  32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h0);
        alu_op("and", ALU_AND,  32'hFF00, 32'h0FF0, 32'h0F00);
        alu_op("or",  ALU_OR,   32'hFF00, 32'h0FF0, 32'hFFF0);
        alu_op("undef_code", 4'd5, 32'd1, 32'd1, 32'h0);
        ForwardAE = 2'd3; ResultW = 32'd99;
        alu_op("fwd_code3", ALU_ADD, 32'd10, 32'd1, 32'd11);
        ForwardAE = FWD_REG;

        // MULTU followed by a stalled MFHI
        RD1E = 32'hFFFF_FFFF; RD2E = 32'd2; MduOpE = MDU_MULTU; RegWrtE = 1'b1; RD_E = 5'd9;
        settle();
        check("multu_issue_stall", {31'b0, MduStallE}, 32'h0);
        tick();
        check("multu_regwrt", {31'b0, RegWrtMem}, 32'h0);
        MduOpE = MDU_MFHI;
        settle();
        stall_cnt = 0;
        for (int i = 0; i < 40 && MduStallE; i++) begin
            stall_cnt++;
            tick();
            if (i == 0 || i == 31) check("multu_bubble", mem_or(), 32'h0);
        end
        check("multu_stall_cycles", stall_cnt, 32'd32);
        tick();
        check("mfhi", ALU_ResultMem, 32'd1);
        check("mfhi_regwrt", {31'b0, RegWrtMem}, 32'h1);
        check("mfhi_rd", {27'b0, RD_Mem}, 32'd9);
        MduOpE = MDU_MFLO;
        tick();
        check("mflo", ALU_ResultMem, 32'hFFFF_FFFE);

        run_mdu("divu_100_7", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        run_mdu("divu_by0", MDU_DIVU, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF);
        run_mdu("multu_big", MDU_MULTU, 32'h8000_0001, 32'h8000_0001, 32'h4000_0001, 32'h0000_0001);
        run_mdu("divu_bigdiv", MDU_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 32'h1);

        // Reset in busy cycle 10 of a DIVU
        RD1E = 32'd100; RD2E = 32'd7; MduOpE = MDU_DIVU;
        tick();
        MduOpE = MDU_MFLO;
        for (int i = 0; i < 9; i++) tick();
        check("abort_busy_before", {31'b0, MduStallE}, 32'h1);
        rst = 1'b1;
        tick();
        check("abort_stall", {31'b0, MduStallE}, 32'h0);
        check("abort_mem", mem_or(), 32'h0);
        rst = 1'b0;
        tick();
        check("abort_mflo", ALU_ResultMem, 32'h0);
        MduOpE = MDU_MFHI;
        tick();
        check("abort_mfhi", ALU_ResultMem, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage MIPS pipeline. Feeds the memory stage directly.
- Selects ALU operands through forwarding muxes and computes the ALU result and branch Zero flag.
- Runs an iterative unsigned multiply/divide unit that writes HI/LO.
- Registers everything the memory stage consumes into the EX/MEM pipeline register.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register-address width
MDU_CYCLES, 32, iterations per MULTU/DIVU (must equal DATA_W)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
RegWrtE  in  1  register-write control from ID/EX
MemWrtE  in  1  memory-write control
ResultSrcE  in  1  writeback select (0 ALU, 1 memory)
ALUSrcE  in  1  operand B select (0 register, 1 immediate)
ALUCtrlE  in  4  ALU operation code
MduOpE  in  3  0 none, 1 MULTU, 2 DIVU, 3 MFHI, 4 MFLO
RD1E, RD2E  in  32  register-file operands
ImmExtE  in  32  sign-extended immediate
PCplus4E  in  32  PC+4
RD_E  in  5  destination register
ForwardAE, ForwardBE  in  2  0 register, 1 ResultW, 2 ALU_ResultMem
ResultW  in  32  writeback-stage result
ZeroE  out  1  combinational: ALU result == 0
MduStallE  out  1  combinational stall request to hazard unit
RegWrtMem, MemWrtMem, ResultSrcMem  out  1  registered controls
RD_Mem  out  5  registered destination
PCplus4Mem, WriteDataMem, ALU_ResultMem  out  32  registered data

Behaviour:
- Reset (synchronous, rst=1 at rising edge):
  - All EX/MEM outputs become 0.
  - HI and LO become 0, MDU FSM goes to IDLE, busy=0.
  - Reset mid-operation aborts the MDU; no partial HI/LO write.
- Forwarding:
  - SrcA = mux(ForwardAE: RD1E, ResultW, ALU_ResultMem). Code 3 behaves as 0.
  - FwdB = mux(ForwardBE, same sources).
  - SrcB = ALUSrcE ? ImmExtE : FwdB.
  - WriteDataMem is registered from FwdB.
- ALU (combinational, 32-bit, wrap-around, no overflow trap):
  - 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 6 SUB.
  - 7 SLT signed, 8 SLTU, 9 SLL (SrcB << SrcA[4:0]), 10 SRL, 11 SRA.
  - Other codes yield 0.
- Result select: MduOpE=3 gives HI, MduOpE=4 gives LO, otherwise the ALU result.
- MDU FSM states:
  - IDLE: MduOpE in {1,2} with busy=0 loads operands (SrcA, FwdB) and moves to RUN.
  - RUN: counter decrements each cycle. After MDU_CYCLES cycles, goes to IDLE and writes HI/LO on that same edge.
  - busy=1 exactly in RUN.
  - MULTU is shift-add: {HI,LO} = SrcA*FwdB (64-bit).
  - DIVU is restoring division: LO = quotient, HI = remainder.
  - Divide by zero: LO=0xFFFFFFFF, HI=dividend.
- Issue and stall:
  - The MULTU/DIVU instruction itself enters MEM in the start cycle with RegWrtMem=0.
  - MduStallE = busy && (MduOpE != 0).
  - While MduStallE=1, the EX/MEM register captures a bubble (all controls 0, data don't-care but held 0). Upstream holds ID/EX.
  - MFHI/MFLO in the first cycle with busy=0 reads the new HI/LO value.
- Back-to-back MDU op: the second op stalls until IDLE, then starts in that cycle.
- Latency: one clock from EX inputs to EX/MEM outputs. ZeroE and MduStallE are same-cycle.

Decomposition:
- Shared package mips_pkg holds:
  - ALU_* opcode constants (4-bit)
  - MDU_NONE/MULTU/DIVU/MFHI/MFLO (3-bit)
  - FWD_REG/FWD_WB/FWD_MEM (2-bit)
- Sub-module mdu_iter holds the FSM, counter, 64-bit accumulator, and HI/LO registers.
  - Interface: clk, rst, start, op, a, b, busy, hi, lo.
- ALU, forwarding muxes, and the EX/MEM register stay inline in execute_stage.

Test Plan:
1. RD1E=5, RD2E=7, ALUCtrlE=ADD, RegWrtE=1, RD_E=3 -> next cycle ALU_ResultMem=12, RegWrtMem=1, RD_Mem=3; ZeroE=0.
2. Following cycle: ForwardAE=2, RD2E=3, ALUCtrlE=SUB -> ALU_ResultMem=9. Then ForwardAE=1, ResultW=0x80000000, SLT against 0 -> 1; SLTU -> 0.
3. SW: ALUSrcE=1, ImmExtE=8, RD1E=0x100, ForwardBE=1, ResultW=0xDEADBEEF, MemWrtE=1 -> ALU_ResultMem=0x108, WriteDataMem=0xDEADBEEF, MemWrtMem=1.
4. MULTU 0xFFFFFFFF x 2, then MFHI held in EX -> MduStallE=1 for 32 cycles with bubbles in MEM. Then MFHI gives 1, and next MFLO gives 0xFFFFFFFE.
5. DIVU 100/7 -> LO=14, HI=2. DIVU 0x1234/0 -> LO=0xFFFFFFFF, HI=0x1234.
6. rst=1 at busy cycle 10 of a DIVU -> next cycle busy=0, MduStallE=0, all EX/MEM outputs 0; MFLO afterwards returns 0.
